// File: rtl/commit_trace_unit.sv
// Commit trace unit: queues GRF/DM commit records and streams each as PC, ADDR, DATA words.
// Latency: an event at edge N into an idle, empty unit is presented as the PC word after edge N+1.
// Backpressure: words advance only on out_valid && out_ready; records that find no FIFO slot are dropped and flagged in overflow.
module commit_trace_unit #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     grf_we,
  input  logic [31:0]              grf_pc,
  input  logic [4:0]               grf_addr,
  input  logic [31:0]              grf_wdata,
  input  logic                     dm_we,
  input  logic [31:0]              dm_pc,
  input  logic [31:0]              dm_addr,
  input  logic [31:0]              dm_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_word,
  output logic                     out_type,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1C = CW'(DEPTH - 1);

  typedef struct packed {
    logic        typ;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  typedef enum logic [1:0] {IDLE, PC, ADDR, DATA} state_t;

  rec_t          mem [DEPTH];
  rec_t          hold;
  rec_t          grf_rec;
  rec_t          dm_rec;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  state_t        state;
  state_t        state_nxt;
  logic          pop;
  logic          grf_ev;
  logic          push_grf;
  logic          push_dm;
  logic          drop;

  // Admission: room is judged on the pre-edge count only; GRF claims the first free slot.
  always_comb begin
    grf_rec  = {1'b0, grf_pc, 27'd0, grf_addr, grf_wdata};
    dm_rec   = {1'b1, dm_pc, dm_addr, dm_wdata};
    grf_ev   = grf_we && (grf_addr != 5'd0);
    push_grf = grf_ev && (count < DEPTH_C);
    push_dm  = dm_we && (push_grf ? (count < DEPTH_M1C) : (count < DEPTH_C));
    drop     = (grf_ev && !push_grf) || (dm_we && !push_dm);
  end

  // FIFO bookkeeping: pointers wrap naturally at DEPTH; overflow is sticky until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_grf) + PW'(push_dm);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push_grf) + CW'(push_dm) - CW'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  // Record storage; a dual event lands GRF then DM in consecutive slots.
  always_ff @(posedge clk) begin
    if (push_grf) mem[wr_ptr] <= grf_rec;
    if (push_dm)  mem[wr_ptr + PW'(push_grf)] <= dm_rec;
  end

  // Emitter state and the holding register for the record being streamed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      if (pop) hold <= mem[rd_ptr];
    end
  end

  // Emitter next state and word mux; DATA acceptance chains straight into the next record.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    out_valid = 1'b0;
    out_word  = 32'd0;
    out_type  = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = PC;
        end
      end
      PC: begin
        out_valid = 1'b1;
        out_word  = hold.pc;
        out_type  = hold.typ;
        if (out_ready) state_nxt = ADDR;
      end
      ADDR: begin
        out_valid = 1'b1;
        out_word  = hold.addr;
        out_type  = hold.typ;
        if (out_ready) state_nxt = DATA;
      end
      DATA: begin
        out_valid = 1'b1;
        out_word  = hold.data;
        out_type  = hold.typ;
        out_last  = 1'b1;
        if (out_ready) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = PC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/commit_trace_unit.md
COMMIT_TRACE_UNIT -- requirements
Module: commit_trace_unit

Interface
REQ-001 Parameter: DEPTH, default 8, trace FIFO depth in records (power of two, >= 2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 grf_we  input  1  register-file write commit this cycle.
REQ-005 grf_pc  input  32  PC of committing GRF-writing instruction.
REQ-006 grf_addr  input  5  destination register number.
REQ-007 grf_wdata  input  32  value written to register.
REQ-008 dm_we  input  1  data-memory write commit this cycle.
REQ-009 dm_pc  input  32  PC of committing store.
REQ-010 dm_addr  input  32  byte address of store.
REQ-011 dm_wdata  input  32  value stored.
REQ-012 out_valid  output  1  out_word valid.
REQ-013 out_ready  input  1  consumer accepts out_word this cycle.
REQ-014 out_word  output  32  current trace word.
REQ-015 out_type  output  1  record type: 0 = GRF, 1 = DM.
REQ-016 out_last  output  1  high on final word (DATA) of a record.
REQ-017 count  output  $clog2(DEPTH)+1  records waiting in FIFO (excludes record being emitted).
REQ-018 overflow  output  1  sticky: at least one commit event dropped.

Function
REQ-019 Record = {type, pc, addr, data}; GRF addr zero-extended from 5 bits to 32.
REQ-020 GRF events with grf_addr = 0 SHALL be discarded silently (no record, no overflow).
REQ-021 Events sampled at rising edge N SHALL be written into FIFO at edge N; count reflects it after N.
REQ-022 Both grf_we and dm_we at same edge: GRF record enqueued first, DM second.
REQ-023 Space check uses pre-edge count; a same-edge pop SHALL NOT create room for pushes.
REQ-024 Event arriving with no slot SHALL be dropped and overflow set; dual event with one slot: GRF kept, DM dropped, overflow set.
REQ-025 overflow SHALL remain 1 until reset.
REQ-026 Emitter FSM states: IDLE, PC, ADDR, DATA.
REQ-027 IDLE: out_valid = 0; if count > 0 at edge, pop head into output holding register and go to PC.
REQ-028 PC/ADDR/DATA: out_valid = 1; out_word = pc / addr / data respectively; out_type = held record type throughout.
REQ-029 out_last = 1 only in DATA.
REQ-030 Transition PC->ADDR->DATA only on edge with out_valid && out_ready; otherwise state and all outputs held stable.
REQ-031 DATA accepted: if count > 0 pop next head and go to PC (back-to-back, no idle cycle); else go IDLE.
REQ-032 Latency: event at edge N into empty unit with FSM IDLE -> out_valid high after edge N+1 with word = pc.
REQ-033 Pop and push at same edge SHALL both take effect; count = old + pushes - pops.
REQ-034 Throughput: one record per 3 accepted words; total capacity DEPTH + 1 records (FIFO + holding).
REQ-035 FIFO pointers wrap modulo DEPTH; full when count = DEPTH, empty when count = 0.

Reset
REQ-036 reset = 1 SHALL immediately (asynchronously) force: state IDLE, FIFO empty, count = 0, overflow = 0, out_valid = 0, out_last = 0, out_type = 0, out_word = 0.
REQ-037 Reset mid-record SHALL abandon the record and all queued records; no partial record emitted after release.
REQ-038 Events present while reset = 1 SHALL be ignored.

Verification
REQ-039 grf_we=1, pc=0x00003000, addr=8, wdata=0x12345678, out_ready=1 -> words 0x00003000, 0x00000008, 0x12345678, type 0, last on third.
REQ-040 grf_we and dm_we same edge (dm pc=0x3004, addr=0x10, data=0xFF) -> GRF record then DM record (type 1), 6 words contiguous.
REQ-041 out_ready=0, 10 GRF events (DEPTH=8) -> count = 8 saturates, overflow = 1; releasing ready yields exactly 9 records in order.
REQ-042 out_ready toggled 1/0 each cycle -> out_word/out_type/out_last unchanged while valid && !ready; no words lost or duplicated.
REQ-043 grf_we=1 with grf_addr=0 -> no record, count stays 0, overflow stays 0.
REQ-044 reset asserted during ADDR word with 3 records queued -> out_valid=0, count=0 immediately; after release no output until new event.
